// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply result is held for MULT_CYCLES. Divide is radix-2 restoring, padded to DIV_CYCLES.
//
// state    | meaning
// IDLE     | waiting for start or an mthi/mtlo write
// MUL      | product latched, counting down to the write-back edge
// DIV_ITER | one quotient bit per cycle, WIDTH cycles
// DIV_FIX  | sign correction and padding up to DIV_CYCLES, then write-back
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = WIDTH + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIX_LOAD = CW'(DIV_CYCLES - WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL      = 2'd1,
    DIV_ITER = 2'd2,
    DIV_FIX  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              load_mul, load_div, div_step, wr_res, wr_hi, wr_lo;

  // acc holds the product for MUL and {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg, r_neg, dzero;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   rem, quo, diff, rem_nx, q_fix, r_fix;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign sgn_a = op[0] & src_a[WIDTH-1];
  assign sgn_b = op[0] & src_b[WIDTH-1];
  assign ext_a = op[0] ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b = op[0] ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;
  assign abs_a = sgn_a ? -src_a : src_a;
  assign abs_b = sgn_b ? -src_b : src_b;

  assign rem     = acc[2*WIDTH-1:WIDTH];
  assign quo     = acc[WIDTH-1:0];
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[WIDTH-1:0] - dvs;
  assign rem_nx  = ge ? diff : shifted[WIDTH-1:0];

  // With a zero divisor the remainder ends up equal to the dividend, so only LO needs overriding
  assign q_fix  = q_neg ? -quo : quo;
  assign r_fix  = r_neg ? -rem : rem;
  assign res_hi = (state == MUL) ? rem : r_fix;
  assign res_lo = (state == MUL) ? quo : (dzero ? {WIDTH{1'b1}} : q_fix);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load_mul = 1'b0;
    load_div = 1'b0;
    div_step = 1'b0;
    wr_res   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op[1]) begin
            state_nx = DIV_ITER;
            cnt_nx   = DIV_LOAD;
            load_div = 1'b1;
          end else begin
            state_nx = MUL;
            cnt_nx   = MUL_LOAD;
            load_mul = 1'b1;
          end
        end else if (hilo_we) begin
          wr_hi = hilo_sel;
          wr_lo = ~hilo_sel;
        end
      end
      MUL: begin
        if (cnt == '0) begin
          wr_res   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DIV_ITER: begin
        div_step = 1'b1;
        if (cnt == '0) begin
          state_nx = DIV_FIX;
          cnt_nx   = FIX_LOAD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DIV_FIX: begin
        if (cnt == '0) begin
          wr_res   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dzero <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= wr_res;
      if (load_mul) begin
        acc <= prod;
      end else if (load_div) begin
        acc   <= {{WIDTH{1'b0}}, abs_a};
        dvs   <= abs_b;
        q_neg <= sgn_a ^ sgn_b;
        r_neg <= sgn_a;
        dzero <= (src_b == '0);
      end else if (div_step) begin
        acc <= {rem_nx, quo[WIDTH-2:0], ge};
      end
      if (wr_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (wr_hi) hi <= hilo_wdata;
        if (wr_lo) lo <= hilo_wdata;
      end
    end
  end

endmodule
